// File: rtl/in_port_req_ctrl.sv
// Requester side of the per-output round-robin arbiters for one router input port.
// XY-routes the head flit, requests the chosen output, then owns it until the tail flit.
module in_port_req_ctrl #(
    parameter int IN_N    = 5,
    parameter int OUT_N   = 5,
    parameter int PORT_ID = 0,
    parameter int FLIT_W  = 16,
    parameter int COORD_W = 4,
    parameter int X_CORD  = 0,
    parameter int Y_CORD  = 0,
    localparam int IDX_W  = (IN_N > 1) ? $clog2(IN_N) : 1,
    localparam int SEL_W  = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [FLIT_W-1:0]      flit_i,
    input  logic                   flit_valid_i,
    output logic                   flit_ready_o,
    output logic [OUT_N-1:0]       out_req_o,
    input  logic [OUT_N*IDX_W-1:0] grant_idx_i,
    output logic [OUT_N-1:0]       out_lock_o,
    output logic [SEL_W-1:0]       out_sel_o,
    output logic [FLIT_W-1:0]      flit_o,
    output logic                   flit_valid_o,
    input  logic                   out_ready_i,
    output logic                   err_o
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t             state;
    state_t             state_next;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [SEL_W-1:0]   route;
    logic               is_head;
    logic               is_tail;
    logic               granted;
    logic               drop;

    // Type bit FLIT_W-1 marks head or head+tail; bit FLIT_W-2 marks tail or head+tail.
    assign dest_x  = flit_i[2*COORD_W-1:COORD_W];
    assign dest_y  = flit_i[COORD_W-1:0];
    assign is_head = flit_i[FLIT_W-1];
    assign is_tail = flit_i[FLIT_W-2];
    assign granted = (grant_idx_i[int'(out_sel_o)*IDX_W +: IDX_W] == IDX_W'(PORT_ID));
    assign flit_o  = flit_i;

    // Dimension-ordered routing: resolve X first, then Y, otherwise eject locally.
    always_comb begin
        route = SEL_W'(0);
        if (dest_x > COORD_W'(X_CORD))
            route = SEL_W'(2);
        else if (dest_x < COORD_W'(X_CORD))
            route = SEL_W'(4);
        else if (dest_y > COORD_W'(Y_CORD))
            route = SEL_W'(1);
        else if (dest_y < COORD_W'(Y_CORD))
            route = SEL_W'(3);
    end

    // The request drops once granted, because the arbiter only grants for one cycle;
    // from then on ownership of the output is signalled through the lock alone.
    always_comb begin
        state_next   = state;
        out_req_o    = '0;
        out_lock_o   = '0;
        flit_ready_o = 1'b0;
        flit_valid_o = 1'b0;
        drop         = 1'b0;
        unique case (state)
            IDLE: begin
                if (flit_valid_i) begin
                    if (is_head) begin
                        state_next = REQ;
                    end else begin
                        drop         = 1'b1;
                        flit_ready_o = 1'b1;
                    end
                end
            end
            REQ: begin
                out_req_o = OUT_N'(1) << out_sel_o;
                if (granted)
                    state_next = XFER;
            end
            XFER: begin
                out_lock_o   = OUT_N'(1) << out_sel_o;
                flit_valid_o = flit_valid_i;
                flit_ready_o = out_ready_i;
                if (flit_valid_i && out_ready_i && is_tail)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            out_sel_o <= '0;
            err_o     <= 1'b0;
        end else begin
            state <= state_next;
            err_o <= drop;
            if (state == IDLE && flit_valid_i && is_head)
                out_sel_o <= route;
        end
    end

endmodule
